// File: rtl/urv_timer_ctrl.sv
// urv_timer_ctrl: memory-mapped 64-bit compare timer with one-shot and periodic modes.
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_n_i       synchronous active-low reset
//   time_i[63:0]  free-running tick count from the core timer
//   addr_i[2:0]   register word address
//   wr_i, rd_i    request strobes; a request is taken when either is high and ack_o is low
//   data_i[31:0]  write data
//   data_o[31:0]  read data, non-zero only while ack_o is high
//   ack_o         one-cycle completion strobe, one cycle after a request is taken
//   irq_o         level interrupt, registered PENDING & IRQ_EN
//
// Register map: 0 CTRL {IRQ_EN,PERIODIC,EN}, 1 STATUS {state[1:0],PENDING(W1C)},
// 2 CMP_LO (shadow), 3 CMP_HI (commits 64-bit compare), 4 PERIOD,
// 5 TIME_LO (snapshots upper half), 6 TIME_HI (snapshot), 7 reserved.
module urv_timer_ctrl #(
  parameter logic [31:0] g_period_reset = 32'd1000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] time_i,
  input  logic [2:0]  addr_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic        pending_q, pending_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] period_q, period_d;
  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;
  logic        irq_q, irq_d;

  logic        acc, wr_acc, rd_acc;
  logic        ctrl_wr, status_wr, cmp_hi_wr;
  logic        hit, hit_eff;
  logic [31:0] rdata;

  // Request decode: a write always wins over a simultaneous read.
  always_comb begin
    acc       = (wr_i | rd_i) & ~ack_q;
    wr_acc    = acc & wr_i;
    rd_acc    = acc & rd_i & ~wr_i;
    ctrl_wr   = wr_acc && (addr_i == 3'd0);
    status_wr = wr_acc && (addr_i == 3'd1);
    cmp_hi_wr = wr_acc && (addr_i == 3'd3);
    hit       = (state_q == ST_ARMED) && (time_i >= cmp_q);
    // A compare update from software overrides a simultaneous hit.
    hit_eff   = hit & ~cmp_hi_wr;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmp_hi_wr && en_q) state_d = ST_ARMED;
      ST_ARMED: if (hit_eff && !periodic_q) state_d = ST_FIRED;
      ST_FIRED: if (cmp_hi_wr) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    if (ctrl_wr) begin
      if (!data_i[0])
        state_d = ST_IDLE;
      else if (!en_q)
        state_d = ST_ARMED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Read mux
  always_comb begin
    rdata = 32'd0;
    case (addr_i)
      3'd0: rdata = {29'd0, irq_en_q, periodic_q, en_q};
      3'd1: rdata = {29'd0, state_q, pending_q};
      3'd2: rdata = shadow_q;
      3'd3: rdata = cmp_q[63:32];
      3'd4: rdata = period_q;
      3'd5: rdata = time_i[31:0];
      3'd6: rdata = snap_q;
      default: rdata = 32'd0;
    endcase
  end

  // Register next state
  always_comb begin
    en_d       = en_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    cmp_d      = cmp_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    period_d   = period_q;
    ack_d      = acc;
    data_d     = rd_acc ? rdata : 32'd0;
    irq_d      = pending_q & irq_en_q;

    if (ctrl_wr) begin
      en_d       = data_i[0];
      periodic_d = data_i[1];
      irq_en_d   = data_i[2];
    end
    if (wr_acc && addr_i == 3'd2) shadow_d = data_i;
    if (wr_acc && addr_i == 3'd4) period_d = data_i;
    if (rd_acc && addr_i == 3'd5) snap_d   = time_i[63:32];

    // Hit sets after the clear so a coincident W1C cannot lose an event.
    if (status_wr && data_i[0]) pending_d = 1'b0;
    if (hit_eff)                pending_d = 1'b1;

    if (cmp_hi_wr)
      cmp_d = {data_i, shadow_q};
    else if (hit_eff && periodic_q)
      cmp_d = cmp_q + {32'd0, period_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
      cmp_q      <= '1;
      shadow_q   <= 32'd0;
      snap_q     <= 32'd0;
      period_q   <= g_period_reset;
      ack_q      <= 1'b0;
      data_q     <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
      cmp_q      <= cmp_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      period_q   <= period_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign irq_o  = irq_q;

endmodule
